// File: rtl/spi_master_ctrl_if.sv
// Command/response bundle between a command source and spi_master_ctrl.
//
// Handshake: a command word moves on a rising clock edge where cmd_valid and
// cmd_ready are both high. The source holds cmd_data stable while cmd_valid
// is high and it has not yet seen cmd_ready. cmd_ready never depends
// combinationally on cmd_valid. rd_valid is a one-cycle strobe with no
// back-pressure; rd_data is meaningful only while rd_valid is high.
interface spi_master_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [9:0] cmd_data;
  logic [7:0] rd_data;
  logic       rd_valid;

  // Command source side (host logic or testbench)
  modport master (
    output cmd_valid,
    output cmd_data,
    input  cmd_ready,
    input  rd_data,
    input  rd_valid
  );

  // spi_master_ctrl side
  modport slave (
    input  cmd_valid,
    input  cmd_data,
    output cmd_ready,
    output rd_data,
    output rd_valid
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// SPI master feeding SPI_Wrapper: one 10-bit RAM transaction word per
// handshake is sent as an 11-bit SS_n-framed MOSI stream. A rd-data word
// (op 2'b11) also waits RD_WAIT cycles and shifts in an 8-bit MISO reply,
// which comes back on rd_data with a one-cycle rd_valid strobe.
// RD_WAIT must be >= 1 and GAP >= 1; both must fit in 8 bits.
module spi_master_ctrl #(
  parameter int RD_WAIT = 2,
  parameter int GAP     = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  spi_master_ctrl_if.slave    cmd_if,
  output logic                busy,
  output logic                SS_n,
  output logic                MOSI,
  input  logic                MISO,
  output logic [2:0]          state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_SHIFT   = 3'd2,
    S_WAIT    = 3'd3,
    S_CAPTURE = 3'd4,
    S_STOP    = 3'd5
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(RD_WAIT - 1);
  localparam logic [7:0] GAP_LOAD  = 8'(GAP);

  state_t      state;
  logic [10:0] shift_q;   // frame bits, MSB goes out first
  logic [3:0]  bit_cnt;   // index of the bit currently on MOSI
  logic [7:0]  wait_cnt;  // cycles spent in WAIT
  logic [2:0]  cap_cnt;   // MISO bits captured so far
  logic [7:0]  gap_cnt;   // SS_n-high cycles still owed before next accept
  logic [7:0]  rx_q;      // MISO reply, shifted in MSB first
  logic        is_rd;     // current frame is a rd-data frame

  assign state_dbg = state;

  // Frame sequencer: state, counters and every output are registered here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      shift_q          <= '0;
      bit_cnt          <= '0;
      wait_cnt         <= '0;
      cap_cnt          <= '0;
      gap_cnt          <= '0;
      rx_q             <= '0;
      is_rd            <= 1'b0;
      SS_n             <= 1'b1;
      MOSI             <= 1'b0;
      busy             <= 1'b0;
      cmd_if.cmd_ready <= 1'b0;
      cmd_if.rd_valid  <= 1'b0;
      cmd_if.rd_data   <= '0;
    end else begin
      cmd_if.rd_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          SS_n <= 1'b1;
          MOSI <= 1'b0;
          if (cmd_if.cmd_valid && cmd_if.cmd_ready) begin
            // Op bit 9 is duplicated in front so the slave sees 11 bits
            shift_q          <= {cmd_if.cmd_data[9], cmd_if.cmd_data};
            is_rd            <= (cmd_if.cmd_data[9:8] == 2'b11);
            bit_cnt          <= '0;
            wait_cnt         <= '0;
            cap_cnt          <= '0;
            state            <= S_START;
            SS_n             <= 1'b0;
            busy             <= 1'b1;
            cmd_if.cmd_ready <= 1'b0;
          end else begin
            // cmd_ready rises on the same edge the gap counter reaches 0
            if (gap_cnt != 8'd0) gap_cnt <= gap_cnt - 8'd1;
            cmd_if.cmd_ready <= (gap_cnt <= 8'd1);
            busy             <= 1'b0;
          end
        end

        S_START: begin
          // One SS_n-low cycle with MOSI=0 lets the slave enter CHK_CMD
          state   <= S_SHIFT;
          MOSI    <= shift_q[10];
          shift_q <= {shift_q[9:0], 1'b0};
          bit_cnt <= '0;
        end

        S_SHIFT: begin
          if (bit_cnt >= 4'd10) begin
            MOSI <= 1'b0;
            if (is_rd) begin
              state    <= S_WAIT;
              wait_cnt <= '0;
            end else begin
              state <= S_STOP;
              SS_n  <= 1'b1;
            end
          end else begin
            MOSI    <= shift_q[10];
            shift_q <= {shift_q[9:0], 1'b0};
            bit_cnt <= bit_cnt + 4'd1;
          end
        end

        S_WAIT: begin
          // Covers the slave's RAM read and load latency before data appears
          MOSI <= 1'b0;
          if (wait_cnt >= WAIT_LAST) begin
            state   <= S_CAPTURE;
            cap_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        S_CAPTURE: begin
          rx_q <= {rx_q[6:0], MISO};
          if (cap_cnt == 3'd7) begin
            state <= S_STOP;
            SS_n  <= 1'b1;
          end else begin
            cap_cnt <= cap_cnt + 3'd1;
          end
        end

        S_STOP: begin
          SS_n             <= 1'b1;
          MOSI             <= 1'b0;
          gap_cnt          <= GAP_LOAD;
          cmd_if.cmd_ready <= 1'b0;
          busy             <= 1'b0;
          state            <= S_IDLE;
          if (is_rd) begin
            cmd_if.rd_valid <= 1'b1;
            cmd_if.rd_data  <= rx_q;
          end
        end

        default: begin
          // Unreachable encodings fall back to a safe idle bus
          state            <= S_IDLE;
          SS_n             <= 1'b1;
          MOSI             <= 1'b0;
          busy             <= 1'b0;
          cmd_if.cmd_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: reset and abort behaviour, a table of
// command words with hand-computed frames and replies, and a back-to-back
// burst. A small behavioural SPI slave with its own RAM answers reads.
module tb_spi_master_ctrl;

  localparam int RD_WAIT = 2;
  localparam int GAP     = 1;
  localparam int LEN_W   = 12;
  localparam int LEN_R   = 20 + RD_WAIT;
  localparam int RD_LAT  = 21 + RD_WAIT;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  logic busy, ss_n_w, mosi_w, miso;
  logic [2:0] state_dbg;
  int   cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_master_ctrl_if cmd_if ();

  spi_master_ctrl #(.RD_WAIT(RD_WAIT), .GAP(GAP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_if    (cmd_if),
    .busy      (busy),
    .SS_n      (ss_n_w),
    .MOSI      (mosi_w),
    .MISO      (miso),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_checks;
  int n_fail;
  logic [10:0] exp_q[$];
  int          exp_len_q[$];
  logic [7:0]  exp_rd_q[$];
  int          acc_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural slave + bus monitor ----------------
  logic [7:0]  mem [256];
  logic [7:0]  s_addr, s_rptr, reply;
  logic [10:0] fw;
  int          low_cnt, high_cnt, frames_done, rdv_cnt;
  bit          mosi_err, seen_frame, prev_rdv;

  always @(negedge clk) begin
    if (!rst_n) begin
      low_cnt    = 0;
      high_cnt   = 0;
      seen_frame = 1'b0;
      prev_rdv   = 1'b0;
      miso       = 1'b0;
    end else begin
      if (!ss_n_w) begin
        if (low_cnt == 0) begin
          if (seen_frame) check("gap_high", 32'(high_cnt >= GAP), 32'd1);
          fw       = '0;
          mosi_err = 1'b0;
        end
        if (low_cnt >= 1 && low_cnt <= 11) fw = {fw[9:0], mosi_w};
        else if ((low_cnt == 0 || (low_cnt >= 12 && low_cnt < 12 + RD_WAIT)) && mosi_w !== 1'b0)
          mosi_err = 1'b1;
        if (low_cnt == 11) begin
          case (fw[9:8])
            2'b00: s_addr = fw[7:0];
            2'b01: mem[s_addr] = fw[7:0];
            2'b10: s_rptr = fw[7:0];
            default: reply = mem[s_rptr];
          endcase
        end
        if (low_cnt >= 12 + RD_WAIT && low_cnt < 20 + RD_WAIT)
          miso = reply[7 - (low_cnt - 12 - RD_WAIT)];
        else
          miso = 1'($urandom_range(0, 1));
        low_cnt++;
      end else begin
        if (low_cnt != 0) begin
          frames_done++;
          seen_frame = 1'b1;
          high_cnt   = 0;
          if (exp_q.size() == 0) check("frame_expected", 32'(exp_q.size()), 32'd1);
          else begin
            check("frame_bits", 32'(fw), 32'(exp_q.pop_front()));
            check("frame_len", 32'(low_cnt), 32'(exp_len_q.pop_front()));
            check("frame_mosi_idle", 32'(mosi_err), 32'd0);
          end
        end
        low_cnt = 0;
        high_cnt++;
        miso = 1'($urandom_range(0, 1));
      end
      // rd_valid strobe: one cycle, fixed latency, expected byte
      if (cmd_if.rd_valid) begin
        rdv_cnt++;
        check("rd_valid_width", 32'(prev_rdv), 32'd0);
        if (exp_rd_q.size() == 0) check("rd_expected", 32'(exp_rd_q.size()), 32'd1);
        else check("rd_data", 32'(cmd_if.rd_data), 32'(exp_rd_q.pop_front()));
        if (acc_q.size() != 0) check("rd_latency", 32'(cyc - acc_q.pop_front()), 32'(RD_LAT));
      end
      prev_rdv = cmd_if.rd_valid;
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [9:0] c, output int acc);
    int t = 0;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_data  = c;
    while (!cmd_if.cmd_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("ready_seen", 32'(cmd_if.cmd_ready), 32'd1);
    acc = cyc + 1;
    @(negedge clk);
    check("ready_drop", 32'(cmd_if.cmd_ready), 32'd0);
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while (busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("frame_done", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [9:0]  cmd;
    logic [10:0] frame;
    int          len;
    bit          has_rd;
    logic [7:0]  rd;
  } vec_t;

  localparam int NV = 10;
  vec_t vec [NV];
  logic [9:0]  b2b_cmd   [4];
  logic [10:0] b2b_frame [4];
  int          b2b_acc   [4];

  initial begin
    int acc, t, rdv_before;
    // mem init: each byte is its address XOR 5A
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    s_addr = '0; s_rptr = '0; reply = '0; fw = '0;
    frames_done = 0; rdv_cnt = 0; n_checks = 0; n_fail = 0; cyc = 0;
    mosi_err = 1'b0;

    vec[0] = '{10'h0A5, 11'h0A5, LEN_W, 1'b0, 8'h00}; // wr-addr A5
    vec[1] = '{10'h13C, 11'h13C, LEN_W, 1'b0, 8'h00}; // wr-data 3C
    vec[2] = '{10'h2A5, 11'h6A5, LEN_W, 1'b0, 8'h00}; // rd-addr A5
    vec[3] = '{10'h300, 11'h700, LEN_R, 1'b1, 8'h3C}; // rd-data -> 3C
    vec[4] = '{10'h07F, 11'h07F, LEN_W, 1'b0, 8'h00}; // wr-addr 7F
    vec[5] = '{10'h1C3, 11'h1C3, LEN_W, 1'b0, 8'h00}; // wr-data C3
    vec[6] = '{10'h27F, 11'h67F, LEN_W, 1'b0, 8'h00}; // rd-addr 7F
    vec[7] = '{10'h3FF, 11'h7FF, LEN_R, 1'b1, 8'hC3}; // rd-data -> C3
    vec[8] = '{10'h2A5, 11'h6A5, LEN_W, 1'b0, 8'h00}; // rd-addr A5
    vec[9] = '{10'h355, 11'h755, LEN_R, 1'b1, 8'h3C}; // rd-data -> 3C
    b2b_cmd[0] = 10'h011; b2b_frame[0] = 11'h011;
    b2b_cmd[1] = 10'h1EE; b2b_frame[1] = 11'h1EE;
    b2b_cmd[2] = 10'h211; b2b_frame[2] = 11'h611;
    b2b_cmd[3] = 10'h300; b2b_frame[3] = 11'h700;

    // reset values
    rst_n = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_data  = '0;
    miso = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ss_n", 32'(ss_n_w), 32'd1);
    check("rst_mosi", 32'(mosi_w), 32'd0);
    check("rst_ready", 32'(cmd_if.cmd_ready), 32'd0);
    check("rst_rd_valid", 32'(cmd_if.rd_valid), 32'd0);
    check("rst_rd_data", 32'(cmd_if.rd_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    rst_n = 1'b1;
    t = 0;
    while (!cmd_if.cmd_ready && t < 20) begin @(negedge clk); t++; end
    check("ready_after_reset", 32'(t <= 1 + GAP), 32'd1);

    // abort a rd-data frame mid-SHIFT with an asynchronous reset
    send(10'h300, acc);
    cmd_if.cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_in_shift", 32'(state_dbg), 32'd2);
    check("abort_ss_low", 32'(ss_n_w), 32'd0);
    rdv_before = rdv_cnt;
    #2 rst_n = 1'b0;
    #1;
    check("abort_ss_async", 32'(ss_n_w), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_state", 32'(state_dbg), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    t = 0;
    while (!cmd_if.cmd_ready && t < 20) begin @(negedge clk); t++; end
    check("ready_after_abort", 32'(t <= 1 + GAP), 32'd1);
    repeat (30) @(negedge clk);
    check("abort_no_rd_valid", 32'(rdv_cnt), 32'(rdv_before));

    // table-driven single commands
    for (int i = 0; i < NV; i++) begin
      exp_q.push_back(vec[i].frame);
      exp_len_q.push_back(vec[i].len);
      if (vec[i].has_rd) exp_rd_q.push_back(vec[i].rd);
      send(vec[i].cmd, acc);
      if (vec[i].has_rd) acc_q.push_back(acc);
      cmd_if.cmd_valid = 1'b0;
      cmd_if.cmd_data  = 10'($urandom);   // must not disturb the frame in flight
      wait_idle();
    end

    // back-to-back: cmd_valid held high across four commands
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(b2b_frame[i]);
      exp_len_q.push_back(i == 3 ? LEN_R : LEN_W);
    end
    exp_rd_q.push_back(8'hEE);
    for (int i = 0; i < 4; i++) begin
      send(b2b_cmd[i], b2b_acc[i]);
      if (i == 3) acc_q.push_back(b2b_acc[i]);
    end
    cmd_if.cmd_valid = 1'b0;
    wait_idle();
    for (int i = 0; i < 3; i++)
      check("b2b_spacing", 32'(b2b_acc[i+1] - b2b_acc[i] >= 14 + GAP), 32'd1);

    // final report
    repeat (5) @(negedge clk);
    check("frames_total", 32'(frames_done), 32'(NV + 4));
    check("rd_total", 32'(rdv_cnt), 32'd4);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("exp_rd_q_drained", 32'(exp_rd_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
